// File: rtl/fuzz_stim_pkg.sv
// Shared types and constants for the equivalence-harness stimulus generator.
package fuzz_stim_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Galois feedback mask for the right-shifting 64-bit LFSR.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // Widths of the four stimulus fields, packed LSB-first out of the LFSR state.
  localparam int W0_W = 16;
  localparam int W1_W = 20;
  localparam int W2_W = 3;
  localparam int W3_W = 14;

  // One Galois right-shift step.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/fuzz_lfsr64.sv
// 64-bit Galois LFSR state holder: synchronous load has priority over step.
module fuzz_lfsr64
  import fuzz_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        step,
  output logic [63:0] state
);

  logic [63:0] state_q, state_d;

  // Next state: load a new seed, advance one step, or hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // State register; reset value is the non-zero default seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 64'h1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fuzz_stim_gen.sv
// Stimulus source for the equivalence harness. Issues optional corner vectors
// then LFSR vectors on a valid/ready handshake, waits a drain window, raises done.
//
// Handshake: a vector transfers on every rising edge where vec_valid and
// vec_ready are both high. vec_valid depends only on registered state, and while
// vec_valid is high without vec_ready the index and data fields hold their values.
module fuzz_stim_gen
  import fuzz_stim_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int CORNER_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      seed,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             vec_ready,
  output logic             vec_valid,
  output logic [CNT_W-1:0] vec_idx,
  output logic [W0_W-1:0]  wire0,
  output logic [W1_W-1:0]  wire1,
  output logic [W2_W-1:0]  wire2,
  output logic [W3_W-1:0]  wire3,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [1:0]       corner_q, corner_d;   // corner vectors accepted so far, saturates at 2

  logic        lfsr_load, lfsr_step;
  logic [63:0] lfsr_state;
  logic [63:0] lfsr_seed;
  logic        is_corner;
  logic [52:0] src;
  logic        lfsr_unused;

  fuzz_lfsr64 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_seed),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  // A zero seed would lock the LFSR, so it is replaced by the default seed.
  assign lfsr_seed   = (seed == 64'h0) ? 64'h1 : seed;
  assign is_corner   = (CORNER_EN != 0) && (corner_q != 2'd2);
  assign lfsr_unused = ^lfsr_state[63:53];

  // FSM next state, counters and LFSR control.
  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    rem_d     = rem_q;
    drain_d   = drain_q;
    corner_d  = corner_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = SEED;
      end
      SEED: begin
        lfsr_load = 1'b1;
        vec_idx_d = '0;
        rem_d     = num_vectors;
        corner_d  = 2'd0;
        drain_d   = '0;
        state_d   = (num_vectors != '0) ? RUN : DRAIN;
      end
      RUN: begin
        if (vec_ready) begin
          vec_idx_d = vec_idx_q + CNT_W'(1);
          rem_d     = rem_q - CNT_W'(1);
          if (is_corner) begin
            corner_d = corner_q + 2'd1;
          end else begin
            lfsr_step = 1'b1;
          end
          if (rem_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_idx_q <= '0;
      rem_q     <= '0;
      drain_q   <= '0;
      corner_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      rem_q     <= rem_d;
      drain_q   <= drain_d;
      corner_q  <= corner_d;
    end
  end

  // Vector source: corner pattern or the current LFSR state.
  always_comb begin
    src = lfsr_state[52:0];
    if (is_corner) begin
      if (corner_q == 2'd1) begin
        src = '1;
      end else begin
        src = '0;
      end
    end
  end

  assign vec_valid = (state_q == RUN);
  assign busy      = (state_q == SEED) || (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
  assign vec_idx   = vec_idx_q;
  assign wire0     = vec_valid ? src[15:0]  : '0;
  assign wire1     = vec_valid ? src[35:16] : '0;
  assign wire2     = vec_valid ? src[38:36] : '0;
  assign wire3     = vec_valid ? src[52:39] : '0;

endmodule
